// File: rtl/count1to10_arbiter_if.sv
// count1to10_arbiter_if: request/length inputs and grant/count/done/busy outputs of the arbiter
interface count1to10_arbiter_if;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] grant;
  logic [3:0] q;
  logic [1:0] done;
  logic       busy;
  modport master (output req, len0, len1, input grant, q, done, busy);
  modport slave  (input req, len0, len1, output grant, q, done, busy);
endinterface

// File: rtl/count1to10_arbiter.sv
// count1to10_arbiter: two-requester round-robin arbiter that runs a shared 1..limit counter for the winner
module count1to10_arbiter (
  input logic clk,
  input logic reset,
  count1to10_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [3:0] limit;
  logic       ptr;
  logic       sel;
  logic       owner;
  logic [3:0] sel_len;
  logic [3:0] clamp;
  // on contention the pointer decides; otherwise the lone requester wins
  always_comb begin
    sel     = &bus.req ? ptr : bus.req[1];
    sel_len = sel ? bus.len1 : bus.len0;
    clamp   = (sel_len == 4'd0 || sel_len > 4'd10) ? 4'd10 : sel_len;
  end
  assign owner    = bus.grant[1];
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      limit     <= '0;
      ptr       <= 1'b0;
      bus.grant <= '0;
      bus.q     <= '0;
      bus.done  <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          state     <= RUN;
          bus.grant <= sel ? 2'b10 : 2'b01;
          bus.q     <= 4'd1;
          limit     <= clamp;
        end
        RUN: if (!bus.req[owner]) begin
          state     <= IDLE;
          bus.grant <= '0;
          bus.q     <= '0;
          ptr       <= ~owner;
        end else if (bus.q == limit) begin
          state     <= DONE;
          bus.done  <= bus.grant;
          bus.grant <= '0;
          bus.q     <= '0;
          ptr       <= ~owner;
        end else begin
          bus.q <= bus.q + 4'd1;
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  a_run_q: assert property (@(posedge clk) disable iff (reset)
    state == RUN |-> bus.q != 4'd0 && bus.q <= 4'd10);
  a_run_grant: assert property (@(posedge clk) disable iff (reset)
    state == RUN |-> $onehot(bus.grant));
endmodule

// File: tb/tb_count1to10_arbiter.sv
// tb_count1to10_arbiter: directed scenario tasks with hand-computed {grant,q,done,busy} expectations
module tb_count1to10_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  count1to10_arbiter_if bus ();
  count1to10_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  logic [8:0] obs;
  assign obs = {bus.grant, bus.q, bus.done, bus.busy};

  function automatic logic [8:0] v(input logic [1:0] g, input logic [3:0] qq, input logic [1:0] d, input logic b);
    return {g, qq, d, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.len0 = '0;
    bus.len1 = '0;
    #1 reset = 1'b1;
    #1;
    tests++;
    if (obs !== 9'd0) begin $display("FAIL reset_async got %h want %h", obs, 9'd0); fails++; end
    tick();
    tests++;
    if (obs !== 9'd0) begin $display("FAIL reset_held got %h want %h", obs, 9'd0); fails++; end
    reset = 1'b0;
    tick();
    tests++;
    if (obs !== 9'd0) begin $display("FAIL reset_idle got %h want %h", obs, 9'd0); fails++; end
  endtask

  task automatic test_contention();
    logic [8:0] e [11];
    e = '{v(1,1,0,1), v(1,2,0,1), v(0,0,1,1), v(0,0,0,0), v(2,1,0,1), v(2,2,0,1),
          v(2,3,0,1), v(2,4,0,1), v(0,0,2,1), v(0,0,0,0), v(1,1,0,1)};
    reset = 1'b1;
    #1 reset = 1'b0;
    bus.req = 2'b11;
    bus.len0 = 4'd2;
    bus.len1 = 4'd4;
    for (int i = 0; i < 11; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin $display("FAIL contention[%0d] got %h want %h", i, obs, e[i]); fails++; end
    end
    bus.req = '0;
    tick();
    tests++;
    if (obs !== 9'd0) begin $display("FAIL contention_abort got %h want %h", obs, 9'd0); fails++; end
  endtask

  task automatic test_single();
    logic [8:0] e [4];
    e = '{v(1,1,0,1), v(1,2,0,1), v(1,3,0,1), v(0,0,1,1)};
    bus.req = 2'b01;
    bus.len0 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin $display("FAIL single[%0d] got %h want %h", i, obs, e[i]); fails++; end
    end
    bus.req = '0;
    tick();
    tests++;
    if (obs !== 9'd0) begin $display("FAIL single_idle got %h want %h", obs, 9'd0); fails++; end
  endtask

  task automatic test_clamp();
    logic [3:0] lens [2];
    lens = '{4'd0, 4'd12};
    for (int k = 0; k < 2; k++) begin
      bus.req = 2'b01;
      bus.len0 = lens[k];
      for (int i = 1; i <= 10; i++) begin
        tick();
        bus.len0 = 4'd3;
        tests++;
        if (obs !== v(1, 4'(i), 0, 1)) begin
          $display("FAIL clamp_len%0d_q%0d got %h want %h", lens[k], i, obs, v(1, 4'(i), 0, 1)); fails++;
        end
      end
      tick();
      tests++;
      if (obs !== v(0,0,1,1)) begin $display("FAIL clamp_len%0d_done got %h want %h", lens[k], obs, v(0,0,1,1)); fails++; end
      bus.req = '0;
      tick();
      tests++;
      if (obs !== 9'd0) begin $display("FAIL clamp_len%0d_idle got %h want %h", lens[k], obs, 9'd0); fails++; end
    end
  endtask

  task automatic test_nongranted();
    logic [8:0] e [5];
    e = '{v(1,1,0,1), v(1,2,0,1), v(0,0,1,1), v(0,0,0,0), v(2,1,0,1)};
    bus.req = 2'b01;
    bus.len0 = 4'd2;
    bus.len1 = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) bus.req = 2'b11;
      tests++;
      if (obs !== e[i]) begin $display("FAIL nongranted[%0d] got %h want %h", i, obs, e[i]); fails++; end
    end
    bus.req = '0;
    tick();
    tests++;
    if (obs !== 9'd0) begin $display("FAIL nongranted_abort got %h want %h", obs, 9'd0); fails++; end
  endtask

  task automatic test_abort();
    bus.req = 2'b10;
    bus.len1 = 4'd1;
    tick();
    tests++;
    if (obs !== v(2,1,0,1)) begin $display("FAIL abort_pre_run got %h want %h", obs, v(2,1,0,1)); fails++; end
    tick();
    tests++;
    if (obs !== v(0,0,2,1)) begin $display("FAIL abort_pre_done got %h want %h", obs, v(0,0,2,1)); fails++; end
    bus.req = 2'b01;
    bus.len0 = 4'd5;
    tick();
    tick();
    tests++;
    if (obs !== v(1,1,0,1)) begin $display("FAIL abort_q1 got %h want %h", obs, v(1,1,0,1)); fails++; end
    tick();
    tests++;
    if (obs !== v(1,2,0,1)) begin $display("FAIL abort_q2 got %h want %h", obs, v(1,2,0,1)); fails++; end
    bus.req = '0;
    tick();
    tests++;
    if (obs !== 9'd0) begin $display("FAIL abort_idle got %h want %h", obs, 9'd0); fails++; end
    tick();
    tests++;
    if (obs !== 9'd0) begin $display("FAIL abort_no_done got %h want %h", obs, 9'd0); fails++; end
    bus.req = 2'b11;
    tick();
    tests++;
    if (obs !== v(2,1,0,1)) begin $display("FAIL abort_ptr got %h want %h", obs, v(2,1,0,1)); fails++; end
    bus.req = '0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.req = 2'b11;
    bus.len0 = 4'd8;
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests++;
      if (obs !== v(1, 4'(i), 0, 1)) begin $display("FAIL areset_q%0d got %h want %h", i, obs, v(1, 4'(i), 0, 1)); fails++; end
    end
    #3 reset = 1'b1;
    #1;
    tests++;
    if (obs !== 9'd0) begin $display("FAIL areset_run got %h want %h", obs, 9'd0); fails++; end
    #1 reset = 1'b0;
    tick();
    tests++;
    if (obs !== v(1,1,0,1)) begin $display("FAIL areset_regrant got %h want %h", obs, v(1,1,0,1)); fails++; end
    bus.req = '0;
    tick();
    bus.req = 2'b01;
    bus.len0 = 4'd1;
    tick();
    tick();
    tests++;
    if (obs !== v(0,0,1,1)) begin $display("FAIL areset_pre_done got %h want %h", obs, v(0,0,1,1)); fails++; end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (obs !== 9'd0) begin $display("FAIL areset_done got %h want %h", obs, 9'd0); fails++; end
    reset = 1'b0;
    bus.req = '0;
    tick();
    tests++;
    if (obs !== 9'd0) begin $display("FAIL areset_after got %h want %h", obs, 9'd0); fails++; end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_clamp();
    test_nongranted();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
